// File: rtl/adc_stream_buffer_pkg.sv
// Shared types for the ADC stream buffer: capture FSM states and FIFO entry layout.
// An entry is {chan[CHAN_W-1:0], data[W_OUT-1:0]}.
package adc_stream_buffer_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCapture = 2'd1,
    StDone    = 2'd2
  } state_e;

  localparam int unsigned CHAN_W = 4;

  function automatic int unsigned entry_width(input int unsigned w_out);
    return CHAN_W + w_out;
  endfunction

endpackage

// File: rtl/adc_stream_buffer_fifo.sv
// First-word-fall-through synchronous FIFO with flush; the head sits in an output register
// that mirrors the oldest stored entry, so count_o includes the displayed head.
module sync_fifo_fwft #(
  parameter int unsigned WIDTH = 20,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             valid_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o,
  output logic [CW-1:0]    count_next_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             valid_q, valid_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop  = pop_i & valid_q & ~flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Head is taken only from entries already in memory, giving a two-cycle write-to-head latency.
  always_comb begin
    valid_d = 1'b0;
    rdata_d = rdata_q;
    if (!flush_i) begin
      valid_d = ((count_q - CW'(do_pop)) != '0);
      if (valid_d) rdata_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
      valid_q  <= valid_d;
    end
  end

  assign rdata_o      = rdata_q;
  assign valid_o      = valid_q;
  assign count_o      = count_q;
  assign count_next_o = count_d;

endmodule

// File: rtl/adc_stream_buffer.sv
// Multi-channel ADC capture buffer: per-channel latest registers, per-channel decimation,
// A/B write arbiter with a one-entry skid, and a channel-tagged FWFT sample FIFO.
module adc_stream_buffer
  import adc_stream_buffer_pkg::*;
#(
  parameter int unsigned N_ADC = 8,
  parameter int unsigned W_ADC = 18,
  parameter int unsigned W_OUT = 16,
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned W_DEC = 16,
  localparam int unsigned FILL_W = $clog2(DEPTH) + 1
) (
  input  logic                   clk50_in,
  input  logic                   reset_in,
  input  logic [N_ADC-1:0]       adc_data_valid_in,
  input  logic [W_ADC-1:0]       adc_data_a_in,
  input  logic [W_ADC-1:0]       adc_data_b_in,
  input  logic [N_ADC-1:0]       chan_en_in,
  input  logic [W_DEC-1:0]       decim_in,
  input  logic                   mode_in,
  input  logic                   arm_in,
  input  logic                   read_in,
  output logic [W_OUT-1:0]       data_out,
  output logic [CHAN_W-1:0]      chan_out,
  output logic                   data_valid_out,
  output logic [FILL_W-1:0]      fill_out,
  output logic                   overflow_out,
  output logic                   done_out,
  output logic [N_ADC*W_OUT-1:0] latest_out
);

  localparam int unsigned HALF    = N_ADC / 2;
  localparam int unsigned ENTRY_W = entry_width(W_OUT);

  state_e               state_q, state_d;
  logic                 mode_q, mode_d;
  logic                 ovf_q, ovf_d;
  logic                 skid_vld_q, skid_vld_d;
  logic [ENTRY_W-1:0]   skid_q, skid_d;
  logic [W_DEC-1:0]     dec_cnt_q [N_ADC];
  logic [W_DEC-1:0]     dec_cnt_d [N_ADC];
  logic [W_OUT-1:0]     latest_q [N_ADC];
  logic [W_OUT-1:0]     latest_d [N_ADC];

  logic [N_ADC-1:0]     win, acc;
  logic                 hit_a, hit_b, acc_a, acc_b;
  logic [CHAN_W-1:0]    idx_a, idx_b;
  logic [W_OUT-1:0]     samp_a, samp_b;
  logic [ENTRY_W-1:0]   ent_a, ent_b;

  logic                 push;
  logic [ENTRY_W-1:0]   push_data;
  logic [ENTRY_W-1:0]   fifo_rdata;
  logic                 fifo_valid, fifo_full, fifo_empty;
  logic [FILL_W-1:0]    fill, fill_next;

  assign samp_a = adc_data_a_in[W_ADC-1 -: W_OUT];
  assign samp_b = adc_data_b_in[W_ADC-1 -: W_OUT];
  assign ent_a  = {idx_a, samp_a};
  assign ent_b  = {idx_b, samp_b};

  // Lowest set valid bit on each bus wins.
  always_comb begin
    win   = '0;
    hit_a = 1'b0;
    hit_b = 1'b0;
    idx_a = '0;
    idx_b = '0;
    for (int i = 0; i < HALF; i++) begin
      if (adc_data_valid_in[i] && !hit_a) begin
        hit_a  = 1'b1;
        idx_a  = CHAN_W'(i);
        win[i] = 1'b1;
      end
      if (adc_data_valid_in[HALF+i] && !hit_b) begin
        hit_b       = 1'b1;
        idx_b       = CHAN_W'(HALF + i);
        win[HALF+i] = 1'b1;
      end
    end
  end

  always_comb begin
    acc = '0;
    for (int j = 0; j < N_ADC; j++) begin
      latest_d[j]  = latest_q[j];
      dec_cnt_d[j] = dec_cnt_q[j];
      if (win[j]) begin
        latest_d[j] = (j < HALF) ? samp_a : samp_b;
        if (chan_en_in[j]) begin
          if (dec_cnt_q[j] == '0) begin
            acc[j]       = 1'b1;
            dec_cnt_d[j] = decim_in;
          end else begin
            dec_cnt_d[j] = dec_cnt_q[j] - 1'b1;
          end
        end
      end
      if (arm_in) dec_cnt_d[j] = '0;
    end
  end

  assign acc_a = |acc[HALF-1:0];
  assign acc_b = |acc[N_ADC-1:HALF];

  // Candidates in order skid, A, B: first goes to the FIFO, second to the skid, third dropped.
  always_comb begin
    ovf_d      = ovf_q;
    skid_vld_d = skid_vld_q;
    skid_d     = skid_q;
    push       = 1'b0;
    push_data  = skid_q;
    if (arm_in) begin
      ovf_d      = 1'b0;
      skid_vld_d = 1'b0;
    end else if (state_q == StCapture) begin
      if (fifo_full) begin
        if (acc_a || acc_b) ovf_d = 1'b1;
      end else begin
        case ({skid_vld_q, acc_a, acc_b})
          3'b111: begin
            push   = 1'b1;
            skid_d = ent_a;
            ovf_d  = 1'b1;
          end
          3'b110: begin
            push   = 1'b1;
            skid_d = ent_a;
          end
          3'b101: begin
            push   = 1'b1;
            skid_d = ent_b;
          end
          3'b100: begin
            push       = 1'b1;
            skid_vld_d = 1'b0;
          end
          3'b011: begin
            push       = 1'b1;
            push_data  = ent_a;
            skid_d     = ent_b;
            skid_vld_d = 1'b1;
          end
          3'b010: begin
            push      = 1'b1;
            push_data = ent_a;
          end
          3'b001: begin
            push      = 1'b1;
            push_data = ent_b;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    if (arm_in) begin
      state_d = StCapture;
      mode_d  = mode_in;
    end else if (state_q == StCapture && mode_q && fill_next == FILL_W'(DEPTH)) begin
      state_d = StDone;
    end
  end

  always_ff @(posedge clk50_in or posedge reset_in) begin
    if (reset_in) begin
      state_q    <= StIdle;
      mode_q     <= 1'b0;
      ovf_q      <= 1'b0;
      skid_vld_q <= 1'b0;
      skid_q     <= '0;
      for (int j = 0; j < N_ADC; j++) begin
        dec_cnt_q[j] <= '0;
        latest_q[j]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      ovf_q      <= ovf_d;
      skid_vld_q <= skid_vld_d;
      skid_q     <= skid_d;
      for (int j = 0; j < N_ADC; j++) begin
        dec_cnt_q[j] <= dec_cnt_d[j];
        latest_q[j]  <= latest_d[j];
      end
    end
  end

  sync_fifo_fwft #(
    .WIDTH(ENTRY_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i       (clk50_in),
    .rst_i       (reset_in),
    .flush_i     (arm_in),
    .push_i      (push),
    .wdata_i     (push_data),
    .pop_i       (read_in & ~fifo_empty),
    .rdata_o     (fifo_rdata),
    .valid_o     (fifo_valid),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fill),
    .count_next_o(fill_next)
  );

  for (genvar j = 0; j < N_ADC; j++) begin : g_latest
    assign latest_out[j*W_OUT +: W_OUT] = latest_q[j];
  end

  assign data_out       = fifo_rdata[W_OUT-1:0];
  assign chan_out       = fifo_rdata[ENTRY_W-1 -: CHAN_W];
  assign data_valid_out = fifo_valid;
  assign fill_out       = fill;
  assign overflow_out   = ovf_q;
  assign done_out       = (state_q == StDone);

endmodule
